spi_periph_regs: RTL and testbench

SPI peripheral (responder) that terminates the frames produced by our APB SPI controller. Each transfer is an 8-bit address byte followed by an 8-bit data byte, both LSB first. The block decodes write and read commands and maintains a small local register file. A host-side read port and a write-event strobe let downstream logic consume the received values.

---
 rtl/spi_periph_regs.sv | 168 ++++++++++++++++
 tb/tb_spi_periph_regs.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_periph_regs.sv
// spi_periph_regs: SPI responder that terminates address+data frames (LSB first)
// from the APB SPI controller. It keeps a small register file, raises a
// write-event strobe for every SPI write, and offers a registered host read port.
`timescale 1ns/1ps
module spi_periph_regs #(
  parameter int DEPTH = 8,
  parameter int IW    = 3
) (
  input  logic          pclk_i,
  input  logic          prst_i,
  input  logic          sclk_i,
  input  logic          cs_n_i,
  input  logic          mosi_i,
  output logic          miso_o,
  output logic          miso_oe_o,
  input  logic [IW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic          wr_evt_o,
  output logic [IW-1:0] wr_idx_o,
  output logic [7:0]    wr_data_o,
  output logic          frame_err_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA_WR, DATA_RD} state_t;

  // DEPTH at index width + 1 so "index < DEPTH" works without a 32-bit compare.
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  // [0] and [1] are the synchroniser stages, [2] is the edge-detect history.
  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_high;
  logic mosi_bit;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [6:0]    rx_sr;    // first seven bits of the current byte, bit 0 at [0]
  logic [6:0]    tx_sr;    // read bits still to be shifted out after miso_o
  logic [IW-1:0] idx_reg;
  logic [7:0]    regs [DEPTH];

  logic [IW-1:0] addr_idx;
  logic          addr_idx_ok;
  logic          idx_reg_ok;
  logic [7:0]    rd_val;

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_high   = cs_sync[1];
  assign mosi_bit  = mosi_sync[1];

  // On the 8th address bit rx_sr already holds addr[6:0]; the index is its low bits.
  assign addr_idx    = rx_sr[IW-1:0];
  assign addr_idx_ok = {1'b0, addr_idx} < DEPTH_W;
  assign idx_reg_ok  = {1'b0, idx_reg} < DEPTH_W;
  assign rd_val      = addr_idx_ok ? regs[addr_idx] : 8'h00;

  // Bring the SPI pins into the pclk domain. CS resets to "asserted" so a CS
  // that is already low at reset release never looks like a fresh falling edge.
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      sclk_sync <= 3'b000;
      cs_sync   <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], sclk_i};
      cs_sync   <= {cs_sync[1:0], cs_n_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
    end
  end

  // Frame FSM: byte assembly, register writes, read shift-out and abort handling.
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      rx_sr       <= 7'd0;
      tx_sr       <= 7'd0;
      idx_reg     <= '0;
      miso_o      <= 1'b0;
      miso_oe_o   <= 1'b0;
      wr_evt_o    <= 1'b0;
      wr_idx_o    <= '0;
      wr_data_o   <= 8'h00;
      frame_err_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      wr_evt_o    <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ADDR;
            bit_cnt <= 3'd0;
          end
        end
        default: begin
          if (cs_high) begin
            // CS released: silent at a byte boundary, an abort otherwise.
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            miso_oe_o <= 1'b0;
            if (bit_cnt != 3'd0) begin
              frame_err_o <= 1'b1;
            end
          end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
            rx_sr   <= {mosi_bit, rx_sr[6:1]};
            if (bit_cnt == 3'd7) begin
              case (state)
                ADDR: begin
                  idx_reg <= addr_idx;
                  if (mosi_bit) begin
                    state <= DATA_WR;
                  end else begin
                    // Preload bit 0 so it is valid before the first data rising edge.
                    state     <= DATA_RD;
                    tx_sr     <= rd_val[7:1];
                    miso_o    <= rd_val[0];
                    miso_oe_o <= 1'b1;
                  end
                end
                DATA_WR: begin
                  state <= ADDR;
                  if (idx_reg_ok) begin
                    regs[idx_reg] <= {mosi_bit, rx_sr};
                    wr_evt_o      <= 1'b1;
                    wr_idx_o      <= idx_reg;
                    wr_data_o     <= {mosi_bit, rx_sr};
                  end
                end
                default: begin
                  state     <= ADDR;
                  miso_oe_o <= 1'b0;
                end
              endcase
            end
          end else if (sclk_fall && state == DATA_RD && bit_cnt != 3'd0) begin
            // The fall right after the address byte keeps bit 0 on the line;
            // later falls move on to the next bit.
            miso_o <= tx_sr[0];
            tx_sr  <= {1'b0, tx_sr[6:1]};
          end
        end
      endcase
    end
  end

  // Host read port; a same-cycle SPI write to the same index shows up one cycle later.
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      rd_data_o <= 8'h00;
    end else if ({1'b0, rd_addr_i} < DEPTH_W) begin
      rd_data_o <= regs[rd_addr_i];
    end else begin
      rd_data_o <= 8'h00;
    end
  end

endmodule

// File: tb/tb_spi_periph_regs.sv
// Testbench for spi_periph_regs: two instances (DEPTH=8 and DEPTH=6) share the
// SPI pins and host read address; a register-file model predicts write events,
// read-back bytes, frame errors and host reads, which monitors check.
`timescale 1ns/1ps
module tb_spi_periph_regs;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          mosi = 1'b0;
  logic [IW-1:0] rd_addr = '0;
  logic          rd_req = 1'b0;
  logic          rd_req_d = 1'b0;

  logic          miso [2];
  logic          oe   [2];
  logic          evt  [2];
  logic          ferr [2];
  logic [7:0]    rdd  [2];
  logic [7:0]    wdat [2];
  logic [IW-1:0] widx [2];

  spi_periph_regs #(.DEPTH(8), .IW(IW)) dut8 (
    .pclk_i(clk), .prst_i(rst_n), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
    .miso_o(miso[0]), .miso_oe_o(oe[0]), .rd_addr_i(rd_addr), .rd_data_o(rdd[0]),
    .wr_evt_o(evt[0]), .wr_idx_o(widx[0]), .wr_data_o(wdat[0]), .frame_err_o(ferr[0])
  );

  spi_periph_regs #(.DEPTH(6), .IW(IW)) dut6 (
    .pclk_i(clk), .prst_i(rst_n), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
    .miso_o(miso[1]), .miso_oe_o(oe[1]), .rd_addr_i(rd_addr), .rd_data_o(rdd[1]),
    .wr_evt_o(evt[1]), .wr_idx_o(widx[1]), .wr_data_o(wdat[1]), .frame_err_o(ferr[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents per instance plus expected-response queues.
  logic [7:0]  model [2][8];
  logic [10:0] ev_q0[$], ev_q1[$];   // {idx, data}
  logic [7:0]  rd_q0[$], rd_q1[$];   // bytes expected on miso
  logic [7:0]  hr_q0[$], hr_q1[$];   // host read results
  int          err_pend [2];
  int          rbits [2];
  logic [7:0]  racc [2];

  function automatic int dep(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic void check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endfunction

  function automatic void push_ev(input int k, input logic [10:0] v);
    if (k == 0) ev_q0.push_back(v); else ev_q1.push_back(v);
  endfunction
  function automatic void push_rd(input int k, input logic [7:0] v);
    if (k == 0) rd_q0.push_back(v); else rd_q1.push_back(v);
  endfunction
  function automatic void push_hr(input int k, input logic [7:0] v);
    if (k == 0) hr_q0.push_back(v); else hr_q1.push_back(v);
  endfunction

  function automatic bit pop_ev(input int k, output logic [10:0] v);
    v = '0;
    if (k == 0) begin if (ev_q0.size() == 0) return 1'b0; v = ev_q0.pop_front(); end
    else        begin if (ev_q1.size() == 0) return 1'b0; v = ev_q1.pop_front(); end
    return 1'b1;
  endfunction
  function automatic bit pop_rd(input int k, output logic [7:0] v);
    v = '0;
    if (k == 0) begin if (rd_q0.size() == 0) return 1'b0; v = rd_q0.pop_front(); end
    else        begin if (rd_q1.size() == 0) return 1'b0; v = rd_q1.pop_front(); end
    return 1'b1;
  endfunction
  function automatic bit pop_hr(input int k, output logic [7:0] v);
    v = '0;
    if (k == 0) begin if (hr_q0.size() == 0) return 1'b0; v = hr_q0.pop_front(); end
    else        begin if (hr_q1.size() == 0) return 1'b0; v = hr_q1.pop_front(); end
    return 1'b1;
  endfunction

  always @(posedge clk) rd_req_d <= rd_req;

  // Monitor: write events, frame errors and host-read results, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [10:0] e;
      logic [7:0]  h;
      if (evt[k]) begin
        if (!pop_ev(k, e)) begin
          checks++; errors++;
          $display("FAIL wr_evt dut%0d: unexpected pulse idx=%0d data=0x%02h, expected no pulse", k, widx[k], wdat[k]);
        end else begin
          check("wr_evt", k, 32'({widx[k], wdat[k]}), 32'(e));
        end
      end
      if (ferr[k]) begin
        check("frame_err_expected", k, 32'(err_pend[k] > 0), 32'd1);
        if (err_pend[k] > 0) err_pend[k]--;
      end
      if (rd_req_d) begin
        if (!pop_hr(k, h)) begin
          checks++; errors++;
          $display("FAIL host_read dut%0d: got 0x%02h with no expectation queued", k, rdd[k]);
        end else begin
          check("host_read", k, 32'(rdd[k]), 32'(h));
        end
      end
    end
  end

  // Monitor: assemble miso bits on controller rising edges while the output is enabled.
  always @(posedge sclk) begin
    for (int k = 0; k < 2; k++) begin
      logic [7:0] r;
      if (oe[k]) begin
        racc[k]  = {miso[k], racc[k][7:1]};
        rbits[k] = rbits[k] + 1;
        if (rbits[k] == 8) begin
          rbits[k] = 0;
          if (!pop_rd(k, r)) begin
            checks++; errors++;
            $display("FAIL miso_byte dut%0d: got 0x%02h with no read expected", k, racc[k]);
          end else begin
            check("miso_byte", k, 32'(racc[k]), 32'(r));
          end
        end
      end
    end
  end

  // ---- stimulus helpers (all start and end on a falling pclk edge) ----
  task automatic spi_bit(input logic b);
    mosi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // One address+data transfer. nbits=8 completes it; 1..7 aborts mid data byte;
  // 0 releases CS right after the address byte (byte boundary, silent).
  task automatic xfer(input logic [7:0] a, input logic [7:0] d, input int nbits);
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = int'(a[2:0]);
      if (nbits == 8) begin
        if (a[7]) begin
          if (idx < dep(k)) begin
            model[k][idx] = d;
            push_ev(k, {a[2:0], d});
          end
        end else begin
          push_rd(k, (idx < dep(k)) ? model[k][idx] : 8'h00);
        end
      end else if (nbits > 0) begin
        err_pend[k]++;
      end
    end
    $display("xfer %s addr=0x%02h data=0x%02h bits=%0d", a[7] ? "WR" : "RD", a, d, nbits);
    for (int i = 0; i < 8; i++) spi_bit(a[i]);
    for (int i = 0; i < nbits; i++) spi_bit(d[i]);
    if (nbits < 8) cs_high();
  endtask

  task automatic host_read(input logic [IW-1:0] a);
    @(negedge clk);
    rd_addr = a;
    rd_req  = 1'b1;
    for (int k = 0; k < 2; k++) push_hr(k, (int'(a) < dep(k)) ? model[k][a] : 8'h00);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_miso"}, k, 32'(miso[k]), 32'd0);
      check({tag, "_miso_oe"}, k, 32'(oe[k]), 32'd0);
      check({tag, "_rd_data"}, k, 32'(rdd[k]), 32'd0);
      check({tag, "_wr_evt"}, k, 32'(evt[k]), 32'd0);
      check({tag, "_wr_idx"}, k, 32'(widx[k]), 32'd0);
      check({tag, "_wr_data"}, k, 32'(wdat[k]), 32'd0);
      check({tag, "_frame_err"}, k, 32'(ferr[k]), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] a, d;
    int n;
    bit aborted;
    for (int k = 0; k < 2; k++) begin
      err_pend[k] = 0; rbits[k] = 0; racc[k] = 8'h00;
      for (int i = 0; i < 8; i++) model[k][i] = 8'h00;
    end

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single write
    cs_low();
    xfer(8'hD3, 8'h46, 8);
    cs_high();
    host_read(3'd3);

    // Burst of eight writes in one CS assertion
    cs_low();
    for (int i = 0; i < 8; i++) xfer(8'(8'h80 + i), 8'(8'h10 + i), 8);
    cs_high();
    for (int i = 0; i < 8; i++) host_read(3'(i));

    // Read back (0x15 on both), out-of-range read on DEPTH=6 returns 0x00
    cs_low();
    xfer(8'h05, 8'h00, 8);
    xfer(8'h07, 8'hFF, 8);
    cs_high();
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("miso_oe_idle", k, 32'(oe[k]), 32'd0);

    // Out-of-range write: only the DEPTH=8 instance updates
    cs_low();
    xfer(8'h87, 8'hAA, 8);
    xfer(8'h07, 8'h00, 8);
    cs_high();
    host_read(3'd7);

    // Abort mid data byte, then CS release at a byte boundary
    cs_low();
    xfer(8'h82, 8'h99, 4);
    cs_low();
    xfer(8'h84, 8'h77, 0);
    host_read(3'd2);
    host_read(3'd4);

    // Randomised traffic
    for (int g = 0; g < 10; g++) begin
      cs_low();
      n = $urandom_range(1, 4);
      aborted = 1'b0;
      for (int t = 0; t < n; t++) begin
        a = 8'($urandom);
        d = 8'($urandom);
        if (t == n - 1 && a[7] && $urandom_range(0, 3) == 0) begin
          xfer(a, d, $urandom_range(1, 7));
          aborted = 1'b1;
        end else begin
          xfer(a, d, 8);
        end
      end
      if (!aborted) cs_high();
      for (int r = 0; r < 3; r++) host_read(3'($urandom_range(0, 7)));
    end

    // Asynchronous reset in the middle of a data byte, with CS held low afterwards
    host_read(3'd3);
    cs_low();
    for (int i = 0; i < 8; i++) spi_bit(a[0] ? 1'b1 : 1'b1 & (i == 7 || i == 0));
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) model[k][i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    // CS still low from before reset: a whole write frame must be ignored
    $display("xfer WR addr=0x81 data=0x55 bits=8 (CS low since reset, ignored)");
    for (int i = 0; i < 8; i++) spi_bit(i == 0 || i == 7);
    for (int i = 0; i < 8; i++) spi_bit((i % 2) == 0);
    cs_high();
    for (int i = 0; i < 8; i++) host_read(3'(i));

    // Everything that was expected must have been seen
    repeat (20) @(negedge clk);
    check("ev_q_left", 0, 32'(ev_q0.size()), 32'd0);
    check("ev_q_left", 1, 32'(ev_q1.size()), 32'd0);
    check("rd_q_left", 0, 32'(rd_q0.size()), 32'd0);
    check("rd_q_left", 1, 32'(rd_q1.size()), 32'd0);
    check("hr_q_left", 0, 32'(hr_q0.size()), 32'd0);
    check("hr_q_left", 1, 32'(hr_q1.size()), 32'd0);
    check("err_left", 0, 32'(err_pend[0]), 32'd0);
    check("err_left", 1, 32'(err_pend[1]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
